dmem_apb_arbiter: RTL and testbench

Two-port arbiter and APB master sequencer for the data-memory bus. Port 0 is the core load/store unit; port 1 is an auxiliary requester (debug/DMA). The block owns the single dmem APB master and grants one request at a time, round-robin on contention. It runs the full APB SETUP/ACCESS sequence, performs lane alignment, byte strobes, misalignment checks and a wait-state timeout, and returns the response to the owning port only.

---
 rtl/dmem_apb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_apb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_apb_arbiter.sv
// rtl/dmem_apb_arbiter.sv - two-port round-robin arbiter driving the dmem APB master
module dmem_apb_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_write_0,
  input  logic [1:0]  req_size_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_write_1,
  input  logic [1:0]  req_size_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  logic            r_last_grant;
  logic            r_port;
  logic            r_write;
  logic [1:0]      r_addr_lo;
  logic [CW-1:0]   r_wait_cnt;

  logic            w_grant;
  logic            w_accept;
  logic            w_write;
  logic [1:0]      w_size;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_misaligned;
  logic [3:0]      w_strb;
  logic [31:0]     w_rdata_aligned;
  logic            w_timeout;

  // On a tie the port that did not win last time gets the bus
  always_comb begin
    w_grant = 1'b0;
    if (req_valid_0 && req_valid_1) w_grant = ~r_last_grant;
    else if (req_valid_1)           w_grant = 1'b1;
  end

  assign w_accept    = (r_state == S_IDLE) && (req_valid_0 || req_valid_1);
  assign req_ready_0 = w_accept && !w_grant;
  assign req_ready_1 = w_accept && w_grant;

  assign w_write = w_grant ? req_write_1 : req_write_0;
  assign w_size  = w_grant ? req_size_1  : req_size_0;
  assign w_addr  = w_grant ? req_addr_1  : req_addr_0;
  assign w_wdata = w_grant ? req_wdata_1 : req_wdata_0;

  assign w_misaligned = (w_size == 2'd3) ||
                        ((w_size == 2'd1) && w_addr[0]) ||
                        ((w_size == 2'd2) && (w_addr[1:0] != 2'b00));

  always_comb begin
    w_strb = 4'b0000;
    case (w_size)
      2'd0:    w_strb = 4'b0001 << w_addr[1:0];
      2'd1:    w_strb = 4'b0011 << {w_addr[1], 1'b0};
      2'd2:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  assign w_rdata_aligned = prdata >> {r_addr_lo, 3'b000};
  assign w_timeout       = (TIMEOUT != 0) && (r_wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_write      <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_wait_cnt   <= '0;
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'h0;
      paddr        <= 32'h0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      pwdata       <= 32'h0;
      pstrb        <= 4'b0000;
    end else begin
      // Response fields are single-cycle; they read 0 outside RESP
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_port       <= w_grant;
            r_write      <= w_write;
            r_addr_lo    <= w_addr[1:0];
            if (w_misaligned) begin
              r_state     <= S_RESP;
              rsp_valid_0 <= !w_grant;
              rsp_valid_1 <= w_grant;
              rsp_err     <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              psel    <= 1'b1;
              paddr   <= {w_addr[31:2], 2'b00};
              pwrite  <= w_write;
              pwdata  <= w_wdata << {w_addr[1:0], 3'b000};
              pstrb   <= w_write ? w_strb : 4'b0000;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            r_state     <= S_RESP;
            rsp_valid_0 <= !r_port;
            rsp_valid_1 <= r_port;
            rsp_err     <= pslverr;
            rsp_rdata   <= (r_write || pslverr) ? 32'h0 : w_rdata_aligned;
          end else if (w_timeout) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            r_state     <= S_RESP;
            rsp_valid_0 <= !r_port;
            rsp_valid_1 <= r_port;
            rsp_err     <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// tb/tb_dmem_apb_arbiter.sv - directed scoreboard bench for dmem_apb_arbiter
module tb_dmem_apb_arbiter;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic        req_valid_0, req_ready_0, req_write_0;
  logic [1:0]  req_size_0;
  logic [31:0] req_addr_0, req_wdata_0;
  logic        req_valid_1, req_ready_1, req_write_1;
  logic [1:0]  req_size_1;
  logic [31:0] req_addr_1, req_wdata_1;
  logic        rsp_valid_0, rsp_valid_1, rsp_err;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  int          slv_waits = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt = 0;
  int          acc_total = 0;
  int          setup_cnt = 0;
  logic [31:0] obs_paddr, obs_pwdata;
  logic        obs_pwrite;
  logic [3:0]  obs_pstrb;

  dmem_apb_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_write_0(req_write_0),
    .req_size_0(req_size_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_write_1(req_write_1),
    .req_size_1(req_size_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // APB slave: pready rises in the (slv_waits+1)-th ACCESS cycle
  always @(negedge clk) begin
    if (psel && penable) begin
      if (acc_cnt == 0) begin
        obs_paddr  = paddr;
        obs_pwrite = pwrite;
        obs_pwdata = pwdata;
        obs_pstrb  = pstrb;
      end
      acc_cnt++;
      acc_total++;
      if (acc_cnt == slv_waits + 1) begin
        pready  = 1'b1;
        prdata  = slv_rdata;
        pslverr = slv_err;
      end else begin
        pready  = 1'b0;
        prdata  = 32'h0BAD_F00D;
        pslverr = 1'b0;
      end
    end else begin
      if (psel) setup_cnt++;
      acc_cnt = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  // Response monitor pops the scoreboard on every response pulse
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid_0 || rsp_valid_1) begin
      check("rsp_onehot", {31'h0, rsp_valid_0 & rsp_valid_1}, 32'h0);
      check("sb_nonempty", {31'h0, sb_q.size() != 0}, 32'h1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rsp_port", {31'h0, rsp_valid_1}, {31'h0, e.port});
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end else if (rst_n) begin
      check("idle_rsp_err", {31'h0, rsp_err}, 32'h0);
      check("idle_rsp_rdata", rsp_rdata, 32'h0);
    end
  end

  task automatic drive(input int port, input logic v, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (port == 0) begin
      req_valid_0 = v; req_write_0 = wr; req_size_0 = sz; req_addr_0 = a; req_wdata_0 = wd;
    end else begin
      req_valid_1 = v; req_write_1 = wr; req_size_1 = sz; req_addr_1 = a; req_wdata_1 = wd;
    end
  endtask

  task automatic run_req(input string tag, input int port, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int waits,
                         input logic serr, input logic [31:0] rd);
    logic mis, eerr;
    logic [31:0] erdata, ewdata;
    logic [3:0] estrb;
    int eacc, elat, base_setup, base_acc, lat;
    logic acc, got;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    eerr = mis || (waits >= TO) || serr;
    erdata = (eerr || wr) ? 32'h0 : (rd >> (8 * a[1:0]));
    ewdata = wd << (8 * a[1:0]);
    case (sz)
      2'd0: estrb = 4'b0001 << a[1:0];
      2'd1: estrb = 4'b0011 << (2 * a[1]);
      default: estrb = 4'b1111;
    endcase
    if (!wr) estrb = 4'b0000;
    eacc = mis ? 0 : ((waits + 1 < TO) ? waits + 1 : TO);
    elat = mis ? 1 : 2 + eacc;
    slv_waits = waits; slv_err = serr; slv_rdata = rd;
    base_setup = setup_cnt; base_acc = acc_total;
    sb_q.push_back('{port: port[0], err: eerr, rdata: erdata});
    drive(port, 1'b1, wr, sz, a, wd);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = (port == 0) ? req_ready_0 : req_ready_1;
    end
    check({tag, "_accept"}, {31'h0, acc}, 32'h1);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid_0 || rsp_valid_1) begin got = 1'b1; lat = k; end
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_setups"}, setup_cnt - base_setup, mis ? 0 : 1);
    check({tag, "_access_cycles"}, acc_total - base_acc, eacc);
    if (!mis) begin
      check({tag, "_paddr"}, obs_paddr, {a[31:2], 2'b00});
      check({tag, "_pwrite"}, {31'h0, obs_pwrite}, {31'h0, wr});
      check({tag, "_pstrb"}, {28'h0, obs_pstrb}, {28'h0, estrb});
      if (wr) check({tag, "_pwdata"}, obs_pwdata, ewdata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic acc, seen;
    int n;
    rst_n = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", {31'h0, psel}, 32'h0);
    check("rst_penable", {31'h0, penable}, 32'h0);
    check("rst_pwrite", {31'h0, pwrite}, 32'h0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_pstrb", {28'h0, pstrb}, 32'h0);
    check("rst_rsp_valid", {30'h0, rsp_valid_1, rsp_valid_0}, 32'h0);
    check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ready", {30'h0, req_ready_1, req_ready_0}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("p0_word_load", 0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    run_req("p1_byte_store", 1, 1'b1, 2'd0, 32'h0000_0203, 32'h0000_005A, 0, 1'b0, 32'h0);
    run_req("p0_half_load", 0, 1'b0, 2'd1, 32'h0000_0102, 32'h0, 2, 1'b0, 32'h1234_5678);
    run_req("p1_half_store", 1, 1'b1, 2'd1, 32'h0000_0012, 32'h0000_BEEF, 1, 1'b0, 32'h0);
    run_req("mis_half", 0, 1'b0, 2'd1, 32'h0000_0101, 32'h0, 0, 1'b0, 32'h1111_1111);
    run_req("after_mis", 1, 1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
    run_req("mis_size3", 1, 1'b0, 2'd3, 32'h0000_0000, 32'h0, 0, 1'b0, 32'h2222_2222);
    run_req("mis_word", 0, 1'b1, 2'd2, 32'h0000_0046, 32'h1, 0, 1'b0, 32'h0);
    run_req("timeout", 1, 1'b0, 2'd2, 32'h0000_0080, 32'h0, 10, 1'b0, 32'h3333_3333);
    run_req("last_wait_ok", 0, 1'b0, 2'd0, 32'h0000_0081, 32'h0, TO - 1, 1'b0, 32'hA1B2_C3D4);
    run_req("slverr", 0, 1'b0, 2'd2, 32'h0000_0090, 32'h0, 1, 1'b1, 32'h4444_4444);

    // Reset during ACCESS: bus drops at once, transfer is discarded
    slv_waits = 50;
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req_ready_0; end
    check("rst_mid_accept", {31'h0, acc}, 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = psel && penable; end
    check("rst_mid_in_access", {31'h0, seen}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_psel", {31'h0, psel}, 32'h0);
    check("rst_mid_penable", {31'h0, penable}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_rsp", {30'h0, rsp_valid_1, rsp_valid_0}, 32'h0);
    @(posedge clk); #1;

    // Contention: both ports always valid, grants alternate starting with port 0
    slv_waits = 0; slv_err = 1'b0;
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd2, 32'h0000_0024, 32'h0);
    for (int i = 0; i < 6; i++) begin
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
        @(negedge clk); n++;
        acc = req_ready_0 || req_ready_1;
      end
      check("tie_accept", {31'h0, acc}, 32'h1);
      check("tie_grant", {31'h0, req_ready_1}, i % 2);
      check("tie_ready_onehot", {31'h0, req_ready_0 & req_ready_1}, 32'h0);
      if (i > 0) check("tie_gap", n, 4);
      slv_rdata = 32'hC0DE_0000 | i;
      sb_q.push_back('{port: i[0], err: 1'b0, rdata: 32'hC0DE_0000 | i});
      @(posedge clk); #1;
      if (i == 5) begin
        drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      end
    end
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("tie_drained", sb_q.size(), 0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
